// File: rtl/store_tracker_pkg.sv
// Shared types and helpers for the store credit tracker: configuration record,
// drain FSM state encoding and the non-idempotent address decode.
package store_tracker_pkg;

  localparam int unsigned NrMaxRules = 4;

  typedef struct packed {
    int unsigned                  PLEN;
    int unsigned                  MEM_TID_WIDTH;
    int unsigned                  DCACHE_MAX_TX;
    int unsigned                  MaxOutstandingStores;
    bit                           NonIdemPotenceEn;
    int unsigned                  NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]  NonIdempotentLength;
  } cfg_t;

  // Neutral default configuration; real cores override every field.
  localparam cfg_t cva6_cfg_empty = '{
    PLEN:                  56,
    MEM_TID_WIDTH:         2,
    DCACHE_MAX_TX:         4,
    MaxOutstandingStores:  2,
    NonIdemPotenceEn:      1'b0,
    NrNonIdempotentRules:  0,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   '0
  };

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  function automatic int unsigned min_u(int unsigned a, int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Address hits any active rule window [base, base+len).
  function automatic logic is_non_idempotent(cfg_t cfg, logic [63:0] addr);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NrMaxRules); i++) begin
      if ((i < int'(cfg.NrNonIdempotentRules)) &&
          (addr >= cfg.NonIdempotentAddrBase[i]) &&
          (addr < (cfg.NonIdempotentAddrBase[i] + cfg.NonIdempotentLength[i]))) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/store_id_alloc.sv
// Transaction ID allocator: registered busy bitmap with set/clear ports and a
// lowest-free-ID priority encoder on the registered state.
module store_id_alloc #(
  parameter int unsigned NUM_ID = 4,
  parameter int unsigned ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ID_W-1:0]   set_id,
  input  logic              clr_en,
  input  logic [ID_W-1:0]   clr_id,
  output logic [NUM_ID-1:0] busy,
  output logic [ID_W-1:0]   free_id,
  output logic              free_vld
);

  logic [NUM_ID-1:0] set_mask;
  logic [NUM_ID-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_id] = 1'b1;
    if (clr_en) clr_mask[clr_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= (busy | set_mask) & ~clr_mask;
    end
  end

  // Scan downwards so the last hit written is the lowest free index.
  always_comb begin
    free_vld = 1'b0;
    free_id  = '0;
    for (int i = int'(NUM_ID) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_vld = 1'b1;
        free_id  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/store_credit_tracker.sv
// Store credit tracker between the store unit and the D$ port: ID allocation,
// in-flight bound, non-idempotent serialisation, fence drain. Optional watchdog
// is enabled by defining STORE_TRACKER_WATCHDOG_EN.
module store_credit_tracker
  import store_tracker_pkg::*;
#(
  parameter cfg_t CVA6Cfg = cva6_cfg_empty,
  localparam int unsigned PLEN   = CVA6Cfg.PLEN,
  localparam int unsigned TID_W  = CVA6Cfg.MEM_TID_WIDTH,
  localparam int unsigned NUM_ID = 1 << TID_W,
  localparam int unsigned LIMIT  = min_u(CVA6Cfg.MaxOutstandingStores, CVA6Cfg.DCACHE_MAX_TX),
  localparam int unsigned CNT_W  = $clog2(LIMIT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [PLEN-1:0]  req_addr_i,
  output logic [TID_W-1:0] req_tid_o,
  input  logic             rsp_valid_i,
  input  logic [TID_W-1:0] rsp_tid_i,
  input  logic             fence_i,
  output logic             fence_done_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  logic [NUM_ID-1:0] busy;
  logic [TID_W-1:0]  free_id;
  logic              free_vld;
  logic              ni_req;
  logic              accept;
  logic              rsp_hit;
  logic              rsp_miss;
  logic              wd_err;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ni_pending_q;
  logic [TID_W-1:0]  ni_tid_q;
  logic              err_q;
  logic              fence_done_q;

  store_id_alloc #(
    .NUM_ID (NUM_ID),
    .ID_W   (TID_W)
  ) u_id_alloc (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .set_en   (accept),
    .set_id   (free_id),
    .clr_en   (rsp_hit),
    .clr_id   (rsp_tid_i),
    .busy     (busy),
    .free_id  (free_id),
    .free_vld (free_vld)
  );

  assign ni_req = CVA6Cfg.NonIdemPotenceEn ? is_non_idempotent(CVA6Cfg, 64'(req_addr_i)) : 1'b0;

  // A fence in the same cycle wins over a pending request.
  assign req_ready_o = (state_q == IDLE) & ~fence_i & (cnt_q < CNT_W'(LIMIT)) & free_vld &
                       ~(ni_req & (cnt_q != '0)) & ~ni_pending_q;
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_hit     = rsp_valid_i & busy[rsp_tid_i];
  assign rsp_miss    = rsp_valid_i & ~busy[rsp_tid_i];

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, rsp_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Drain FSM; done pulses in the cycle after the count reaches zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fence_done_q <= 1'b0;
    end else begin
      fence_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fence_i) begin
            if (cnt_d == '0) fence_done_q <= 1'b1;
            else             state_q      <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_d == '0) begin
            fence_done_q <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      ni_pending_q <= 1'b0;
      ni_tid_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | rsp_miss | wd_err;
      if (accept && ni_req) begin
        ni_pending_q <= 1'b1;
        ni_tid_q     <= free_id;
      end else if (rsp_hit && ni_pending_q && (rsp_tid_i == ni_tid_q)) begin
        ni_pending_q <= 1'b0;
      end
    end
  end

`ifdef STORE_TRACKER_WATCHDOG_EN
  logic [15:0] wd_q;

  // Counts stalled cycles with stores in flight; saturates at all-ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q <= '0;
    end else if (rsp_valid_i || (cnt_q == '0)) begin
      wd_q <= '0;
    end else if (wd_q != 16'hFFFF) begin
      wd_q <= wd_q + 16'd1;
    end
  end

  assign wd_err = (wd_q == 16'hFFFF);
`else
  assign wd_err = 1'b0;
`endif

  assign req_tid_o    = free_id;
  assign cnt_o        = cnt_q;
  assign err_o        = err_q;
  assign fence_done_o = fence_done_q;

endmodule

// File: tb/tb_store_credit_tracker.sv
// Self-checking bench for store_credit_tracker: directed scenarios plus random
// traffic compared against a transaction-level reference model.
module tb_store_credit_tracker;
  import store_tracker_pkg::*;

  localparam cfg_t TB_CFG = '{
    PLEN:                  34,
    MEM_TID_WIDTH:         2,
    DCACHE_MAX_TX:         4,
    MaxOutstandingStores:  2,
    NonIdemPotenceEn:      1'b1,
    NrNonIdempotentRules:  1,
    NonIdempotentAddrBase: '0,
    NonIdempotentLength:   {64'h0, 64'h0, 64'h0, 64'h1000}
  };
  localparam logic [33:0] HI_ADDR = 34'h0_8000_0000;
  localparam logic [33:0] NI_ADDR = 34'h0_0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        ready;
  logic [33:0] req_addr;
  logic [1:0]  tid;
  logic        rsp_valid;
  logic [1:0]  rsp_tid;
  logic        fence;
  logic        done;
  logic [1:0]  cnt;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Reference model state: which IDs are outstanding, plus fence/error flags.
  bit m_busy[4];
  bit m_ni_pend;
  int m_ni_tid;
  bit m_drain;
  bit m_done;
  bit m_err;
  int m_wd;

  always #5 clk = ~clk;

  store_credit_tracker #(.CVA6Cfg(TB_CFG)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (ready),
    .req_addr_i   (req_addr),
    .req_tid_o    (tid),
    .rsp_valid_i  (rsp_valid),
    .rsp_tid_i    (rsp_tid),
    .fence_i      (fence),
    .fence_done_o (done),
    .cnt_o        (cnt),
    .err_o        (err)
  );

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < 4; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic bit m_is_ni(logic [33:0] a);
    return a < 34'h1000;
  endfunction

  function automatic bit m_ready();
    return !m_drain && !fence && (m_cnt() < 2) && (m_free() >= 0) &&
           !(m_is_ni(req_addr) && m_cnt() != 0) && !m_ni_pend;
  endfunction

  function automatic logic [1:0] m_tid();
    return (m_free() < 0) ? 2'd0 : 2'(m_free());
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_busy[i] = 1'b0;
    m_ni_pend = 1'b0;
    m_ni_tid  = 0;
    m_drain   = 1'b0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_wd      = 0;
  endtask

  // Applies one clock edge to the model, then advances the DUT clock.
  task automatic tick();
    bit acc;
    bit hit;
    bit fence_go;
    int lf;
    acc = req_valid && m_ready();
    lf  = m_free();
    hit = rsp_valid && m_busy[rsp_tid];
    if (rsp_valid && !m_busy[rsp_tid]) m_err = 1'b1;
`ifdef STORE_TRACKER_WATCHDOG_EN
    if (m_wd == 65535) m_err = 1'b1;
    if (rsp_valid || m_cnt() == 0) m_wd = 0;
    else if (m_wd != 65535) m_wd++;
`endif
    fence_go = m_drain || fence;
    if (hit) begin
      m_busy[rsp_tid] = 1'b0;
      if (m_ni_pend && m_ni_tid == int'(rsp_tid)) m_ni_pend = 1'b0;
    end
    if (acc) begin
      m_busy[lf] = 1'b1;
      if (m_is_ni(req_addr)) begin
        m_ni_pend = 1'b1;
        m_ni_tid  = lf;
      end
    end
    m_done  = fence_go && (m_cnt() == 0);
    m_drain = fence_go && (m_cnt() != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    req_addr  = HI_ADDR;
    rsp_valid = 1'b0;
    rsp_tid   = 2'd0;
    fence     = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic complete_all();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_busy[i]) begin
        rsp_valid = 1'b1;
        rsp_tid   = 2'(i);
        @(negedge clk);
        tick();
      end
    end
    rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tid !== 2'd0 || cnt !== 2'd0 || err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ready=%0b tid=%0d cnt=%0d err=%0b done=%0b want 1/0/0/0/0",
               ready, tid, cnt, err, done);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 1'b1;
    req_addr  = HI_ADDR;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || tid !== 2'(k)) begin
        failures++;
        $display("FAIL b2b_accept%0d ready=%0b tid=%0d want 1/%0d", k, ready, tid, k);
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || cnt !== 2'd2) begin
        failures++;
        $display("FAIL b2b_held ready=%0b cnt=%0d want 0/2", ready, cnt);
      end
      tick();
    end
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rsp_cycle ready=%0b want 0", ready);
    end
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tid !== 2'd0 || cnt !== 2'd1) begin
      failures++;
      $display("FAIL b2b_third ready=%0b tid=%0d cnt=%0d want 1/0/1", ready, tid, cnt);
    end
    tick();
    complete_all();
  endtask

  task automatic test_non_idempotent();
    do_reset();
    req_valid = 1'b1;
    req_addr  = HI_ADDR;
    @(negedge clk);
    tick();
    req_addr = NI_ADDR;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL ni_wait_cnt ready=%0b want 0", ready);
      end
      tick();
    end
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    @(negedge clk);
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tid !== 2'd0) begin
      failures++;
      $display("FAIL ni_accept ready=%0b tid=%0d want 1/0", ready, tid);
    end
    tick();
    req_addr = HI_ADDR;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || cnt !== 2'd1) begin
        failures++;
        $display("FAIL ni_pending_stall ready=%0b cnt=%0d want 0/1", ready, cnt);
      end
      tick();
    end
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    @(negedge clk);
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tid !== 2'd0) begin
      failures++;
      $display("FAIL ni_release ready=%0b tid=%0d want 1/0", ready, tid);
    end
    tick();
    complete_all();
  endtask

  task automatic test_fence();
    do_reset();
    req_valid = 1'b1;
    req_addr  = HI_ADDR;
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    fence = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL fence_same_cycle ready=%0b want 0", ready);
    end
    tick();
    fence = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL fence_drain ready=%0b done=%0b want 0/0", ready, done);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      rsp_valid = 1'b1;
      rsp_tid   = 2'(k);
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL fence_drain_rsp ready=%0b done=%0b want 0/0", ready, done);
      end
      tick();
    end
    rsp_valid = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cnt !== 2'd0) begin
      failures++;
      $display("FAIL fence_done_pulse done=%0b cnt=%0d want 1/0", done, cnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL fence_done_width done=%0b want 0", done);
    end
    fence = 1'b1;
    tick();
    fence = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL fence_empty done=%0b want 1", done);
    end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_valid = 1'b1;
    req_addr  = HI_ADDR;
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    req_valid = 1'b0;
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    @(negedge clk);
    tick();
    req_valid = 1'b1;
    rsp_tid   = 2'd1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tid !== 2'd0 || cnt !== 2'd1) begin
      failures++;
      $display("FAIL same_cycle_accept ready=%0b tid=%0d cnt=%0d want 1/0/1", ready, tid, cnt);
    end
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || tid !== 2'd1 || cnt !== 2'd1) begin
      failures++;
      $display("FAIL same_cycle_after ready=%0b tid=%0d cnt=%0d want 1/1/1", ready, tid, cnt);
    end
    tick();
    complete_all();
  endtask

  task automatic test_unknown_id();
    do_reset();
    rsp_valid = 1'b1;
    rsp_tid   = 2'd3;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL unknown_pre err=%0b want 0", err);
    end
    tick();
    rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (err !== 1'b1 || cnt !== 2'd0) begin
        failures++;
        $display("FAIL unknown_sticky err=%0b cnt=%0d want 1/0", err, cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      case ($urandom_range(0, 3))
        0:       req_addr = 34'($urandom_range(0, 32'hFFF));
        1:       req_addr = HI_ADDR + 34'($urandom_range(0, 255));
        default: req_addr = 34'($urandom);
      endcase
      r         = $urandom_range(0, 3);
      rsp_tid   = 2'(r);
      rsp_valid = (m_busy[r] && $urandom_range(0, 99) < 45) || ($urandom_range(0, 199) == 0);
      fence     = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      checks++;
      if (ready !== m_ready() || tid !== m_tid() || cnt !== 2'(m_cnt()) ||
          err !== m_err || done !== m_done) begin
        failures++;
        $display("FAIL random_c%0d ready=%0b/%0b tid=%0d/%0d cnt=%0d/%0d err=%0b/%0b done=%0b/%0b (got/want)",
                 c, ready, m_ready(), tid, m_tid(), cnt, m_cnt(), err, m_err, done, m_done);
      end
      tick();
    end
    req_valid = 1'b0;
    rsp_valid = 1'b0;
    fence     = 1'b0;
  endtask

  task automatic test_watchdog();
`ifdef STORE_TRACKER_WATCHDOG_EN
    do_reset();
    req_valid = 1'b1;
    req_addr  = HI_ADDR;
    @(negedge clk);
    tick();
    req_valid = 1'b0;
    repeat (65535) tick();
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cnt !== 2'd1) begin
      failures++;
      $display("FAIL watchdog_early err=%0b cnt=%0d want 0/1", err, cnt);
    end
    tick();
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || err !== m_err) begin
      failures++;
      $display("FAIL watchdog_fire err=%0b want 1", err);
    end
    complete_all();
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 1'b1;
    req_addr  = HI_ADDR;
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    req_valid = 1'b0;
    rsp_valid = 1'b1;
    rsp_tid   = 2'd3;
    @(negedge clk);
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cnt !== 2'd2 || err !== 1'b1) begin
      failures++;
      $display("FAIL async_pre cnt=%0d err=%0b want 2/1", cnt, err);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || tid !== 2'd0 || cnt !== 2'd0 || err !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset ready=%0b tid=%0d cnt=%0d err=%0b done=%0b want 1/0/0/0/0",
               ready, tid, cnt, err, done);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rsp_valid = 1'b1;
    rsp_tid   = 2'd0;
    @(negedge clk);
    tick();
    rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || err !== m_err || cnt !== 2'd0) begin
      failures++;
      $display("FAIL async_stale_rsp err=%0b cnt=%0d want 1/0", err, cnt);
    end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = HI_ADDR;
    rsp_valid = 1'b0;
    rsp_tid   = 2'd0;
    fence     = 1'b0;
    test_reset();
    test_back_to_back();
    test_non_idempotent();
    test_fence();
    test_same_cycle();
    test_unknown_id();
    test_random();
    test_watchdog();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
